// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised input, 3-sample majority per bit,
// false-start rejection, parity/framing/break flags and an end-of-stream pulse.
module uart_rx_cfg #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int IDLE_TIMEOUT = 20_000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 data_end
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD;
  localparam int CW       = $clog2(BAUD_CNT);
  localparam int IW       = $clog2(IDLE_TIMEOUT + 1);
  localparam int XW       = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_CNT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(BAUD_CNT / 2);
  localparam logic [XW-1:0] DATA_LAST = XW'(DATA_BITS - 1);
  localparam logic [XW-1:0] STOP_LAST = XW'(STOP_BITS - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);
  localparam logic [IW-1:0] IDLE_PRE  = IW'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             hist_q, hist_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [XW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bit_q, par_bit_d;
  logic                   ferr_acc_q, ferr_acc_d;
  logic [IW-1:0]          idle_q, idle_d;
  logic                   armed_q, armed_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   brk_q, brk_d;
  logic                   dend_q, dend_d;

  logic rx_s, maj, tick, ferr_now, perr_calc;

  assign rx_s = sync_q[SYNC_STAGES-1];
  // Majority over the current and two previous synchronised samples.
  assign maj  = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
  assign tick = (cnt_q == '0);

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
    hist_d     = {hist_q[0], rx_s};
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    ferr_acc_d = ferr_acc_q;
    idle_d     = idle_q;
    armed_d    = armed_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    dend_d     = 1'b0;
    ferr_now   = ferr_acc_q | ~maj;
    if (PARITY == 1)      perr_calc = ~((^shift_q) ^ par_bit_q);
    else if (PARITY == 2) perr_calc = (^shift_q) ^ par_bit_q;
    else                  perr_calc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = CNT_HALF;
        end
      end
      ST_START: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else if (maj) state_d = ST_IDLE;
        else begin
          state_d = ST_DATA;
          cnt_d   = CNT_LAST;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          cnt_d   = CNT_LAST;
          if (idx_q == DATA_LAST) begin
            idx_d      = '0;
            par_bit_d  = 1'b0;
            ferr_acc_d = 1'b0;
            state_d    = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else begin
          par_bit_d = maj;
          cnt_d     = CNT_LAST;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else if (idx_q == STOP_LAST) begin
          data_d  = shift_q;
          perr_d  = perr_calc;
          ferr_d  = ferr_now;
          brk_d   = (shift_q == '0) && !par_bit_q && ferr_now;
          valid_d = 1'b1;
          state_d = ferr_now ? ST_WAIT_HIGH : ST_IDLE;
        end else begin
          ferr_acc_d = ferr_now;
          idx_d      = idx_q + 1'b1;
          cnt_d      = CNT_LAST;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Idle timer saturates; the pulse fires only once per armed stretch.
    if (state_q == ST_IDLE && rx_s) begin
      if (idle_q != IDLE_MAX) begin
        idle_d = idle_q + 1'b1;
        if (idle_q == IDLE_PRE && armed_q) begin
          dend_d  = 1'b1;
          armed_d = 1'b0;
        end
      end
    end else begin
      idle_d = '0;
    end
    if (valid_q) armed_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sync_q     <= '1;
      hist_q     <= 2'b11;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      ferr_acc_q <= 1'b0;
      idle_q     <= '0;
      armed_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      dend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      ferr_acc_q <= ferr_acc_d;
      idle_q     <= idle_d;
      armed_q    <= armed_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      dend_q     <= dend_d;
    end
  end

  assign data       = data_q;
  assign valid_out  = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign break_det  = brk_q;
  assign data_end   = dend_q;

endmodule
